// File: rtl/shift_sub_divider_pkg.sv
// Shared types and sizing for the restoring shift-subtract divider.
package div_pkg;

  localparam int DIV_N = 8;
  localparam int CNT_W = $clog2(DIV_N);

  typedef enum logic [1:0] {IDLE, SHIFT, SUB, DONE} div_state_t;

endpackage

// File: rtl/shift_sub_divider_if.sv
// Host-side handshake and result bus of the divider.
interface shift_sub_divider_if;
  import div_pkg::*;

  logic             start;
  logic [DIV_N-1:0] dividend;
  logic [DIV_N-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [DIV_N-1:0] quotient;
  logic [DIV_N-1:0] remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );

endinterface

// File: rtl/shift_sub_divider_register.sv
// AQ/M datapath: load, shift AQ left, conditional subtract of M from A.
module divider_register
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  logic           shift,
  input  logic           sub,
  input  logic [N-1:0]   Din,
  input  logic [N-1:0]   Min,
  output logic [2*N-1:0] AQ,
  output logic           borrow
);

  logic [N-1:0] m;
  logic [N:0]   trial;

  // A stays below M between steps, so only the borrow needs the extra bit.
  assign trial  = {1'b0, AQ[2*N-1:N]} - {1'b0, m};
  assign borrow = trial[N];

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      AQ <= '0;
      m  <= '0;
    end else if (load) begin
      AQ <= {{N{1'b0}}, Din};
      m  <= Min;
    end else if (shift) begin
      AQ <= {AQ[2*N-2:0], 1'b0};
    end else if (sub && !borrow) begin
      AQ <= {trial[N-1:0], AQ[N-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/shift_sub_divider.sv
// Restoring divider top: control FSM, iteration counter and result registers.
module shift_sub_divider
  import div_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  shift_sub_divider_if.slave   bus
);

  localparam int N = DIV_N;

  div_state_t       state;
  div_state_t       state_next;
  logic [CNT_W-1:0] count;
  logic [2*N-1:0]   aq;
  logic             borrow;
  logic             load;
  logic             shift;
  logic             sub;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic             last;
  logic [N-1:0]     quot_q;
  logic [N-1:0]     rem_q;
  logic             dbz_q;

  assign div_zero = (bus.divisor == '0);
  assign last     = (count == CNT_W'(N-1));

  divider_register #(.N(N)) u_regs (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .shift  (shift),
    .sub    (sub),
    .Din    (bus.dividend),
    .Min    (bus.divisor),
    .AQ     (aq),
    .borrow (borrow)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = div_zero ? DONE : SHIFT;
      SHIFT:   state_next = SUB;
      SUB:     state_next = last ? DONE : SHIFT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load  = 1'b0;
    shift = 1'b0;
    sub   = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    load  = bus.start && !div_zero;
      SHIFT:   begin shift = 1'b1; busy = 1'b1; end
      SUB:     begin sub   = 1'b1; busy = 1'b1; end
      DONE:    done  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          if (div_zero) begin
            quot_q <= '1;
            rem_q  <= bus.dividend;
            dbz_q  <= 1'b1;
          end else begin
            count <= '0;
          end
        end
        SUB: begin
          if (last) dbz_q <= 1'b0;
          else      count <= count + 1'b1;
        end
        DONE: if (!dbz_q) begin
          quot_q <= aq[N-1:0];
          rem_q  <= aq[2*N-1:N];
        end
        default: ;
      endcase
    end
  end

  // During DONE the AQ register already holds the post-subtract result, so it is
  // forwarded directly and then retained in the result registers.
  assign bus.quotient    = (state == DONE && !dbz_q) ? aq[N-1:0]   : quot_q;
  assign bus.remainder   = (state == DONE && !dbz_q) ? aq[2*N-1:N] : rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = busy;
  assign bus.done        = done;

endmodule
